// File: rtl/csa_seq_mult_ctrl.sv
// Iterative shift-and-add multiplier: one partial product per cycle folded into
// carry-save sum/carry registers, then a single carry-propagate resolve.
module csa_seq_mult_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 busy_o
);

    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    ONE_P    = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Most-negative input maps to 2^(WIDTH-1), which still fits unsigned WIDTH bits.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        logic [WIDTH-1:0] r;
        if (sgn && v[WIDTH-1]) begin
            r = ~v + ONE_W;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] maj3(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                           input logic [PW-1:0] z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    sum_q, sum_d;
    logic [PW-1:0]    carry_q, carry_d;
    logic [PW-1:0]    product_q, product_d;
    logic             out_valid_q, out_valid_d;
    logic [PW-1:0]    pp_s;
    logic [PW-1:0]    resolve_s;

    assign pp_s      = mag_b_q[cnt_q] ? ({{WIDTH{1'b0}}, mag_a_q} << cnt_q) : {PW{1'b0}};
    assign resolve_s = sum_q + carry_q;

    // Next-state and datapath update for the four-state controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        neg_d       = neg_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    mag_a_d = abs_val(a_i, signed_i);
                    mag_b_d = abs_val(b_i, signed_i);
                    // A zero operand never yields a negated result.
                    neg_d   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (|a_i) & (|b_i);
                    sum_d   = {PW{1'b0}};
                    carry_d = {PW{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                sum_d   = sum_q ^ carry_q ^ pp_s;
                carry_d = maj3(sum_q, carry_q, pp_s) << 1;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = RESOLVE;
                end else begin
                    state_d = ACCUM;
                end
            end
            RESOLVE: begin
                product_d   = neg_q ? (~resolve_s + ONE_P) : resolve_s;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            mag_a_q     <= {WIDTH{1'b0}};
            mag_b_q     <= {WIDTH{1'b0}};
            neg_q       <= 1'b0;
            sum_q       <= {PW{1'b0}};
            carry_q     <= {PW{1'b0}};
            product_q   <= {PW{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            neg_q       <= neg_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = out_valid_q;
    assign product_o   = product_q;

endmodule

// File: tb/tb_csa_seq_mult_ctrl.sv
// Scoreboard bench for csa_seq_mult_ctrl (WIDTH=8): expected products are queued
// at accept time and popped when the product is presented.
module tb_csa_seq_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          t0 = 0;
    logic [15:0] exp_q[$];

    csa_seq_mult_ctrl #(.WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .signed_i(sgn), .a_i(a), .b_i(b), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .product_o(product), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic signed [15:0] sx, sy;
        logic [15:0] p;
        if (s) begin
            sx = {{8{x[7]}}, x};
            sy = {{8{y[7]}}, y};
            p  = sx * sy;
        end else begin
            p = {8'h00, x} * {8'h00, y};
        end
        return p;
    endfunction

    // Drive one operand pair from a negedge; t0 records the accept edge.
    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic [15:0] e);
        for (int i = 0; i < 30 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        in_valid = 1'b1; a = x; b = y; sgn = s;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        t0 = cyc;
        in_valid = 1'b0; a = ~x; b = ~y; sgn = ~s;
    endtask

    task automatic wait_valid(output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - t0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sgn = 1'b0; a = 8'h00; b = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (product !== 16'h0000) begin bad++; $display("FAIL reset_product got=%h exp=0000", product); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_unsigned();
        logic [7:0] ta[3] = '{8'd101, 8'd255, 8'd0};
        logic [7:0] tb_[3] = '{8'd99, 8'd255, 8'd0};
        logic [15:0] te[3] = '{16'd9999, 16'hFE01, 16'd0};
        int lat; bit bok; logic [15:0] e;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(ta[k], tb_[k], 1'b0, te[k]);
            wait_valid(lat, bok);
            e = exp_q.pop_front();
            total++; if (lat != 9) begin bad++; $display("FAIL uns_latency k=%0d got=%0d exp=9", k, lat); end
            total++; if (product !== e) begin bad++; $display("FAIL uns_product k=%0d got=%h exp=%h", k, product, e); end
            total++; if (!bok) begin bad++; $display("FAIL uns_busy k=%0d busy dropped exp=held", k); end
            @(negedge clk);
            total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || cyc - t0 != 10) begin
                bad++; $display("FAIL uns_return k=%0d in_ready=%b out_valid=%b dt=%0d exp=1,0,10", k, in_ready, out_valid, cyc - t0);
            end
        end
    endtask

    task automatic test_signed();
        logic [7:0] ta[4] = '{8'hFB, 8'h80, 8'h80, 8'd23};
        logic [7:0] tb_[4] = '{8'd7, 8'h80, 8'h7F, 8'hFF};
        logic [15:0] te[4] = '{16'hFFDD, 16'h4000, 16'hC080, 16'hFFE9};
        int lat; bit bok; logic [15:0] e;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(ta[k], tb_[k], 1'b1, te[k]);
            wait_valid(lat, bok);
            e = exp_q.pop_front();
            total++; if (lat != 9 || product !== e) begin
                bad++; $display("FAIL sgn_product k=%0d got=%h lat=%0d exp=%h lat=9", k, product, lat, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int lat; bit bok; logic [15:0] e;
        out_ready = 1'b0;
        send(8'd200, 8'd3, 1'b0, 16'd600);
        wait_valid(lat, bok);
        e = exp_q[0];
        for (int k = 0; k < 5; k++) begin
            in_valid = ~in_valid; a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || product !== e || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold k=%0d out_valid=%b product=%h in_ready=%b exp=1,%h,0", k, out_valid, product, in_ready, e);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== e) begin
            bad++; $display("FAIL bp_release out_valid=%b in_ready=%b product=%h exp=0,1,%h", out_valid, in_ready, product, e);
        end
        @(negedge clk);
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_spurious busy=%b out_valid=%b exp=0,0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit bok; logic [15:0] e;
        out_ready = 1'b1;
        send(8'd200, 8'd200, 1'b0, 16'd40000);
        while (cyc - t0 < 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        total++; if (out_valid !== 1'b0 || product !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_reset out_valid=%b product=%h in_ready=%b busy=%b exp=0,0000,1,0", out_valid, product, in_ready, busy);
        end
        send(8'd12, 8'd12, 1'b0, 16'd144);
        wait_valid(lat, bok);
        e = exp_q.pop_front();
        total++; if (lat != 9 || product !== e) begin
            bad++; $display("FAIL mid_after got=%h lat=%0d exp=%h lat=9", product, lat, e);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat; bit bok; logic [15:0] e; logic [7:0] x, y; logic s;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            x = 8'($urandom); y = 8'($urandom); s = 1'($urandom);
            send(x, y, s, model(x, y, s));
            wait_valid(lat, bok);
            e = exp_q.pop_front();
            total++; if (lat != 9 || product !== e) begin
                bad++; $display("FAIL b2b_product k=%0d a=%h b=%h s=%b got=%h lat=%0d exp=%h", k, x, y, s, product, lat, e);
            end
            for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
            total++; if (cyc - t0 != 10 || in_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_interval k=%0d dt=%0d in_ready=%b exp=10,1", k, cyc - t0, in_ready);
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_seq_mult_ctrl.md
Name: csa_seq_mult_ctrl

Overview:
- Sequential shift-and-add multiplier controller built around a 3:2 carry-save accumulation stage.
- Accepts one operand pair through a valid/ready handshake. Each cycle it folds one partial product into redundant sum/carry registers, then resolves them with one carry-propagate add.
- Supports unsigned and signed (two's complement) modes; this is the iterative, area-lean option of the configurable multiplier.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  operand pair valid
- in_ready_o  out  1  controller can accept operands
- signed_i  in  1  1 = treat a_i/b_i as two's complement, sampled with operands
- a_i  in  WIDTH  multiplicand
- b_i  in  WIDTH  multiplier
- out_valid_o  out  1  product_o valid
- out_ready_i  in  1  consumer accepts product
- product_o  out  2*WIDTH  product (two's complement when signed)
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_i=1 at edge): state=IDLE, counter=0, sum/carry regs=0, product_o=0, out_valid_o=0, busy_o=0. in_ready_o is 1 during the first cycle after reset.
- Reset has priority over every other event. Asserting reset in any state aborts the operation with no output.
- FSM states: IDLE, ACCUM, RESOLVE, DONE.
- IDLE: in_ready_o=1.
  - On in_valid_i&&in_ready_o: latch mag_a=|a|, mag_b=|b| (abs only when signed_i=1, else raw), neg=signed_i&(a[MSB]^b[MSB]), sum=0, carry=0, cnt=0; go to ACCUM.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) is held as an unsigned WIDTH-bit value with no overflow.
- ACCUM: each cycle compute pp = mag_b[cnt] ? (mag_a << cnt) : 0, zero-extended to 2*WIDTH.
  - sum <= sum ^ carry ^ pp; carry <= majority(sum,carry,pp) << 1. All arithmetic is modulo 2^(2*WIDTH) and the carry MSB is discarded.
  - cnt++. When cnt==WIDTH-1 (last bit processed), go to RESOLVE.
  - Exactly WIDTH cycles in ACCUM; no early termination.
- RESOLVE: r = sum + carry (2*WIDTH bits). product_o <= neg ? (~r + 1) : r; out_valid_o <= 1; go to DONE.
- DONE: out_valid_o=1; product_o stable.
  - On out_ready_i=1: out_valid_o <= 0 and go to IDLE.
  - No combinational ready-through: a new operand is not accepted in the same cycle as the DONE handshake.
- Latency:
  - Accept edge at cycle T; out_valid_o first high after edge T+WIDTH+1.
  - With out_ready_i held high, in_ready_o returns after edge T+WIDTH+2.
  - Initiation interval = WIDTH+2 cycles.
- in_valid_i/operands are ignored outside IDLE. Latched operands are unaffected by input changes mid-operation.
- product_o holds its last value after the DONE handshake until the next RESOLVE overwrites it.
- busy_o = (state != IDLE). in_ready_o = (state == IDLE) && !rst_i is not required; in_ready_o is a registered/state decode only.
- Zero operand: still takes full latency; product_o=0; neg forced to 0 when result is 0 (e.g. -3*0 gives 0, never negative zero issues).

Test Plan:
- Unsigned 101*99: signed_i=0, WIDTH=8 -> product_o=16'd9999 with out_valid_o rising exactly 9 cycles after the accept edge.
- Unsigned corner 255*255 and 0*0 -> 16'd65025 (0xFE01) and 16'd0. Each run spends exactly 8 cycles in ACCUM with busy_o high throughout.
- Signed: -5*7 -> 0xFFDD (-35); -128*-128 -> 0x4000 (16384); -128*127 -> 0xC080 (-16256); 23*-1 -> 0xFFE9.
- Back-pressure: hold out_ready_i=0 for 5 cycles after out_valid_o. product_o and out_valid_o stay stable, in_ready_o stays 0, and a toggled in_valid_i is ignored. Release -> handshake, IDLE next cycle.
- Reset mid-operation: pulse rst_i at ACCUM cnt=3 -> next cycle state IDLE, out_valid_o=0, product_o=0, in_ready_o=1. A subsequent 12*12 yields 144.
- Back-to-back: 4 random operand pairs of mixed modes with out_ready_i tied high, checked against a reference model. Each accept must be spaced exactly 10 cycles apart.
